// File: rtl/islemci_kontrol_if.sv
// Instruction-fetch handshake between the control unit (master) and the
// instruction memory (slave).
interface islemci_kontrol_if #(
   parameter int unsigned PC_GENISLIK = 8
);
   logic [PC_GENISLIK-1:0] emir_adres_o;
   logic                   emir_istek_o;
   logic                   emir_gecerli_i;
   logic [15:0]            emir_i;

   modport master (
      output emir_adres_o, emir_istek_o,
      input  emir_gecerli_i, emir_i
   );

   modport slave (
      input  emir_adres_o, emir_istek_o,
      output emir_gecerli_i, emir_i
   );
endinterface

// File: rtl/islemci_kontrol.sv
// Multi-cycle control unit of the 8-bit processor: fetch, decode, execute,
// register write-back, jumps/branches/halt and a saturating retire counter.
module islemci_kontrol #(
   parameter int unsigned            PC_GENISLIK  = 8,
   parameter logic [PC_GENISLIK-1:0] BASLANGIC_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   baslat_i,
   islemci_kontrol_if.master      emir_bus,
   output logic [15:0]            emir_o,
   input  logic [7:0]             veri1_i,
   input  logic [7:0]             veri2_i,
   output logic [2:0]             alu_islem_o,
   input  logic [7:0]             alu_sonuc_i,
   output logic [7:0]             yazilacak_veri_o,
   output logic                   veriyi_yaz_o,
   output logic [PC_GENISLIK-1:0] pc_o,
   output logic                   durdu_o,
   output logic                   hata_o,
   output logic [15:0]            sayac_o
);

   typedef enum logic [2:0] {BOS, GETIR, COZ, YURUT, YAZ, DUR} durum_e;
   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ALU  = 4'h1,
      OP_JMP  = 4'h2,
      OP_BEQ  = 4'h3,
      OP_HALT = 4'hF
   } opkod_e;

   durum_e                 durum_q, durum_d;
   logic [PC_GENISLIK-1:0] pc_q, pc_d;
   logic [15:0]            emir_q, emir_d;
   logic [7:0]             yaz_q, yaz_d;
   logic [15:0]            sayac_q, sayac_d;
   logic                   hata_q, hata_d;

   logic [3:0]             opkod;
   logic [PC_GENISLIK-1:0] pc_art, dal_hedef;
   logic [5:0]             ofs6;
   logic [31:0]            ofs32;
   logic [15:0]            sayac_art;
   logic                   istek, yaz_en, durdu;

   assign opkod     = emir_q[15:12];
   assign pc_art    = pc_q + PC_GENISLIK'(1);
   assign ofs6      = {emir_q[11:9], emir_q[2:0]};
   assign ofs32     = {{26{ofs6[5]}}, ofs6};
   assign dal_hedef = pc_art + PC_GENISLIK'(ofs32);
   assign sayac_art = (sayac_q == '1) ? sayac_q : sayac_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) durum_q <= BOS;
      else     durum_q <= durum_d;
   end

   always_comb begin
      durum_d = durum_q;
      case (durum_q)
         BOS:     if (baslat_i) durum_d = GETIR;
         GETIR:   if (emir_bus.emir_gecerli_i) durum_d = COZ;
         COZ:     durum_d = (opkod == OP_HALT) ? DUR : YURUT;
         YURUT:   durum_d = (opkod == OP_ALU) ? YAZ : GETIR;
         YAZ:     durum_d = GETIR;
         DUR:     if (baslat_i) durum_d = GETIR;
         default: durum_d = BOS;
      endcase
   end

   always_comb begin
      istek  = 1'b0;
      yaz_en = 1'b0;
      durdu  = 1'b0;
      case (durum_q)
         GETIR:    istek  = 1'b1;
         YAZ:      yaz_en = 1'b1;
         BOS, DUR: durdu  = 1'b1;
         default:  ;
      endcase
   end

   // Retire count steps once per instruction: in COZ for HALT, in YAZ for
   // ALU, in YURUT for everything else.
   always_comb begin
      emir_d  = emir_q;
      pc_d    = pc_q;
      yaz_d   = yaz_q;
      sayac_d = sayac_q;
      hata_d  = hata_q;
      case (durum_q)
         GETIR: if (emir_bus.emir_gecerli_i) emir_d = emir_bus.emir_i;
         COZ: begin
            if (opkod == OP_HALT) begin
               pc_d    = pc_art;
               sayac_d = sayac_art;
            end
         end
         YURUT: begin
            sayac_d = sayac_art;
            case (opkod)
               OP_ALU: begin
                  yaz_d   = alu_sonuc_i;
                  sayac_d = sayac_q;
               end
               OP_JMP:  pc_d = PC_GENISLIK'(emir_q[7:0]);
               OP_BEQ:  pc_d = (veri1_i == veri2_i) ? dal_hedef : pc_art;
               OP_NOP:  pc_d = pc_art;
               default: begin
                  pc_d   = pc_art;
                  hata_d = 1'b1;
               end
            endcase
         end
         YAZ: begin
            pc_d    = pc_art;
            sayac_d = sayac_art;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= BASLANGIC_PC;
         emir_q  <= '0;
         yaz_q   <= '0;
         sayac_q <= '0;
         hata_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         emir_q  <= emir_d;
         yaz_q   <= yaz_d;
         sayac_q <= sayac_d;
         hata_q  <= hata_d;
      end
   end

   assign emir_bus.emir_adres_o = pc_q;
   assign emir_bus.emir_istek_o = istek;
   assign emir_o                = emir_q;
   assign alu_islem_o           = emir_q[2:0];
   assign yazilacak_veri_o      = yaz_q;
   assign veriyi_yaz_o          = yaz_en;
   assign pc_o                  = pc_q;
   assign durdu_o               = durdu;
   assign hata_o                = hata_q;
   assign sayac_o               = sayac_q;

endmodule

// File: doc/islemci_kontrol.md
Name: islemci_kontrol

Overview:
- Multi-cycle control unit for the 8-bit processor.
- Fetches 16-bit instructions over a request/valid handshake and holds the current instruction for the 8x8 register file (operand fields [5:3], [8:6]; destination [11:9]).
- Drives the ALU operation, captures the ALU result and pulses the register-file write enable.
- Handles jumps, branches and halt, and counts retired instructions.

Parameters:
- PC_GENISLIK, 8, program counter and instruction-address width.
- BASLANGIC_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- baslat_i  input  1  start/resume pulse (used in BOS and DUR)
- emir_adres_o  output  PC_GENISLIK  instruction fetch address (equals pc_o)
- emir_istek_o  output  1  fetch request
- emir_gecerli_i  input  1  instruction memory data valid
- emir_i  input  16  fetched instruction
- emir_o  output  16  latched current instruction, wired to the register file
- veri1_i  input  8  register-file read data for [5:3]
- veri2_i  input  8  register-file read data for [8:6]
- alu_islem_o  output  3  ALU function = emir_o[2:0]
- alu_sonuc_i  input  8  combinational ALU result
- yazilacak_veri_o  output  8  write-back data to the register file
- veriyi_yaz_o  output  1  register-file write enable, one-cycle pulse
- pc_o  output  PC_GENISLIK  program counter
- durdu_o  output  1  high while in BOS or DUR
- hata_o  output  1  sticky undefined-opcode flag
- sayac_o  output  16  retired-instruction count, saturating

Behaviour:
- Reset values:
  - State BOS; pc_o = BASLANGIC_PC; emir_o = 0.
  - emir_istek_o, veriyi_yaz_o, hata_o = 0; yazilacak_veri_o = 0; sayac_o = 0; durdu_o = 1.
  - Reset wins over every other event, including mid-fetch; emir_istek_o is 0 in the cycle after rst is sampled.
- Opcodes are emir_o[15:12]:
  - 0 NOP.
  - 1 ALU: rd = [11:9], rs1 = [5:3], rs2 = [8:6], function = [2:0].
  - 2 JMP: pc <= emir_o[7:0].
  - 3 BEQ: if veri1_i == veri2_i then pc <= pc + 1 + sext({emir_o[11:9], emir_o[2:0]}), else pc <= pc + 1.
  - F HALT.
  - Any other opcode executes as NOP and sets hata_o (sticky until rst).
- States: BOS, GETIR, COZ, YURUT, YAZ, DUR.
- BOS: wait; baslat_i -> GETIR.
- GETIR:
  - emir_istek_o = 1, and emir_adres_o is held stable until emir_gecerli_i is sampled high.
  - On that edge, emir_o <= emir_i, request drops, -> COZ.
  - emir_gecerli_i is ignored while emir_istek_o = 0.
- COZ: one cycle for register-file read settle.
  - HALT: pc <= pc + 1, sayac increments, -> DUR.
  - Otherwise -> YURUT.
- YURUT:
  - ALU: yazilacak_veri_o <= alu_sonuc_i, -> YAZ.
  - NOP/undefined: pc <= pc + 1, -> GETIR.
  - JMP/BEQ: pc <= target, -> GETIR.
  - Sayac increments for every non-ALU instruction.
- YAZ:
  - veriyi_yaz_o = 1 for exactly this cycle; the register file writes yazilacak_veri_o to emir_o[11:9] at the edge.
  - pc <= pc + 1, sayac increments, -> GETIR.
- DUR: baslat_i -> GETIR at the current pc; otherwise stay.
- baslat_i outside BOS/DUR is ignored.
- Latency with memory valid in the first request cycle:
  - ALU: 4 cycles (GETIR, COZ, YURUT, YAZ).
  - NOP/JMP/BEQ: 3 cycles.
  - HALT: 2 cycles.
- Arithmetic:
  - PC arithmetic is modulo 2^PC_GENISLIK; 0xFF + 1 wraps to 0x00.
  - Branch offset is 6-bit signed (-32..+31) and also wraps modulo 2^PC_GENISLIK.
- sayac_o saturates at 0xFFFF and does not wrap.
- emir_o changes only at fetch accept, so register-file read addresses are stable through COZ, YURUT and YAZ.

Test Plan:
- rst, baslat_i, memory returns 0x1A51 (ALU, rd=5, rs2=1, rs1=2, fn=1) with 1-cycle valid, alu_sonuc_i = 0x2B -> veriyi_yaz_o high exactly 1 cycle, 4 cycles after accept-edge start; yazilacak_veri_o = 0x2B; emir_o[11:9] = 5; pc_o 0 -> 1; sayac_o = 1.
- Memory delays valid by 3 cycles -> emir_istek_o stays 1 and emir_adres_o stays constant for 4 cycles; no veriyi_yaz_o; a stray emir_gecerli_i pulse while idle is ignored.
- JMP 0x20FF at pc = 5 -> pc_o = 0xFF; then NOP -> pc_o wraps to 0x00.
- BEQ 0x3E3F at pc = 0x10 (offset = -1):
  - veri1_i = veri2_i = 7 -> pc_o = 0x10.
  - veri1_i = 7, veri2_i = 8 -> pc_o = 0x11.
- HALT 0xF000 at pc = 3 -> durdu_o = 1, pc_o = 4, no fetch request; baslat_i -> fetch from address 4. Opcode 0x7000 -> hata_o = 1 until rst.
- rst asserted while in GETIR and again while in YAZ -> next cycle state BOS, pc_o = 0, emir_istek_o = 0, veriyi_yaz_o = 0, sayac_o = 0.
